// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int BYTE_W            = 8;
  localparam int UART_FRAME_CYCLES = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART handshake bundle for the arbiter; master drives requests and txdone.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_last;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        grant_ack;
  logic [BYTE_W-1:0]         tx_byte;
  logic                      tx_send;
  logic                      tx_done;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    output req, req_last, req_data, tx_done,
    input  grant_ack, tx_byte, tx_send, busy, timeout_err
  );

  modport slave (
    input  req, req_last, req_data, tx_done,
    output grant_ack, tx_byte, tx_send, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational rotate-priority pick: first set bit of mask_i at or after ptr_i, wrapping.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    return IW'(s);
  endfunction

  // Scan from lowest priority to highest so the candidate nearest ptr_i is written last.
  always_comb begin
    logic [IW-1:0] cand_v;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_v  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_v  = rot_idx(ptr_i, k);
      idx_o   = mask_i[cand_v] ? cand_v : idx_o;
      valid_o = valid_o | mask_i[cand_v];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte sources,
// with message locking and a watchdog on txdone and on a stalled lock owner.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int              IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LIM  = CW'(TIMEOUT);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                tx_send_q, tx_send_d;
  logic [NUM_REQ-1:0]  grant_ack_q, grant_ack_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0]  elig_s;
  logic [IW-1:0]       pick_idx_s;
  logic                pick_vld_s;
  logic [CW-1:0]       cnt_inc_s;

  // While locked only the owner may win, so other requesters simply wait.
  assign elig_s    = lock_q ? (bus.req & (ONE_HOT0 << owner_q)) : bus.req;
  assign cnt_inc_s = (cnt_q == CNT_LIM) ? cnt_q : (cnt_q + CW'(1));

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask_i  (elig_s),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx_s),
    .valid_o (pick_vld_s)
  );

  // Next-state, lock, watchdog counter and registered-output decisions.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lock_d        = lock_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    tx_byte_d     = tx_byte_q;
    tx_send_d     = 1'b0;
    grant_ack_d   = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d     = ST_SEND;
          tx_send_d   = 1'b1;
          grant_ack_d = ONE_HOT0 << pick_idx_s;
          tx_byte_d   = bus.req_data[{pick_idx_s, 3'b000} +: BYTE_W];
          lock_d      = ~bus.req_last[pick_idx_s];
          owner_d     = pick_idx_s;
          rr_ptr_d    = (pick_idx_s == LAST_IDX) ? IW'(0) : (pick_idx_s + IW'(1));
          cnt_d       = '0;
        end else if (lock_q) begin
          if (cnt_q == CNT_LIM) begin
            lock_d        = 1'b0;
            timeout_err_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
        cnt_d   = CW'(1);
      end
      ST_WAIT: begin
        // txdone takes priority over an expiry landing in the same cycle.
        if (bus.tx_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          lock_d        = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        lock_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || lock_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lock_q        <= 1'b0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      tx_byte_q     <= 8'h00;
      tx_send_q     <= 1'b0;
      grant_ack_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_q        <= lock_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_byte_q     <= tx_byte_d;
      tx_send_q     <= tx_send_d;
      grant_ack_q   <= grant_ack_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.grant_ack   = grant_ack_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
